// File: rtl/dc_useq.sv
// ============================================================================
// dc_useq : F-11 microcode sequencer, reader end of the dc_rom store.  Rev 1.0
// ============================================================================
`default_nettype none

module dc_useq #(
  parameter logic [8:0] RESET_ADDR  = 9'h000,
  parameter logic [8:0] TRAP_ADDR   = 9'h008,
  parameter int         STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  rom_a,
  output logic        rom_cen,
  input  logic [8:0]  rom_ma,
  input  logic [15:0] rom_mc,
  input  logic        ax,
  input  logic        stall,
  input  logic        trap_req,
  input  logic        jmp_req,
  input  logic [8:0]  jmp_addr,
  input  logic        call_en,
  input  logic        ret_en,
  output logic [15:0] mc_out,
  output logic        mc_valid,
  output logic [9:0]  cur_addr,
  output logic        stk_err
);

  localparam int            SPW     = $clog2(STACK_DEPTH);
  localparam logic [SPW:0]  SP_FULL = (SPW+1)'(STACK_DEPTH);
  localparam logic [SPW:0]  SP_ONE  = (SPW+1)'(1);

  typedef enum logic [0:0] {
    S_RST = 1'b0,
    S_RUN = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [SPW:0] sp_q, sp_d;
  logic [8:0]   stack_q [STACK_DEPTH];
  logic [9:0]   cur_addr_q;
  logic         stk_err_q, stk_err_d;
  logic         push;
  logic [8:0]   next_addr;
  logic [SPW:0] sp_m1;

  assign sp_m1    = sp_q - SP_ONE;
  assign mc_out   = rom_mc;
  assign cur_addr = cur_addr_q;
  assign stk_err  = stk_err_q;

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    stk_err_d = stk_err_q;
    push      = 1'b0;
    next_addr = rom_ma;
    rom_cen   = 1'b1;
    mc_valid  = 1'b0;
    rom_a     = {ax, RESET_ADDR};
    case (state_q)
      S_RST: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        mc_valid = 1'b1;
        if (stall) begin
          // ROM output frozen; re-present the same address so nothing moves
          rom_cen = 1'b0;
          rom_a   = cur_addr_q;
        end else begin
          if (trap_req) begin
            next_addr = TRAP_ADDR;
            sp_d      = '0;
          end else if (jmp_req && call_en) begin
            next_addr = jmp_addr;
            if (sp_q == SP_FULL) begin
              stk_err_d = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SP_ONE;
            end
          end else if (jmp_req) begin
            next_addr = jmp_addr;
          end else if (ret_en) begin
            if (sp_q == '0) begin
              stk_err_d = 1'b1;
            end else begin
              next_addr = stack_q[sp_m1[SPW-1:0]];
              sp_d      = sp_m1;
            end
          end
          rom_a = {ax, next_addr};
        end
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      sp_q       <= '0;
      stk_err_q  <= 1'b0;
      cur_addr_q <= {1'b0, RESET_ADDR};
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
      if (rom_cen) cur_addr_q <= rom_a;
    end
  end

  // Stack storage needs no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (!rst && push) stack_q[sp_q[SPW-1:0]] <= rom_ma;
  end

endmodule

`default_nettype wire

// File: tb/tb_dc_useq.sv
// Randomized scoreboard bench for dc_useq with a behavioural ROM and stack model.
`default_nettype none

module tb_dc_useq;

  localparam int DEPTH = 4;
  localparam int NCYC  = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rom_a;
  logic        rom_cen;
  logic [8:0]  rom_ma;
  logic [15:0] rom_mc;
  logic        ax, stall, trap_req, jmp_req, call_en, ret_en;
  logic [8:0]  jmp_addr;
  logic [15:0] mc_out;
  logic        mc_valid;
  logic [9:0]  cur_addr;
  logic        stk_err;

  always #5 clk = ~clk;

  dc_useq #(.RESET_ADDR(9'h000), .TRAP_ADDR(9'h008), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rom_a(rom_a), .rom_cen(rom_cen), .rom_ma(rom_ma),
    .rom_mc(rom_mc), .ax(ax), .stall(stall), .trap_req(trap_req),
    .jmp_req(jmp_req), .jmp_addr(jmp_addr), .call_en(call_en), .ret_en(ret_en),
    .mc_out(mc_out), .mc_valid(mc_valid), .cur_addr(cur_addr), .stk_err(stk_err)
  );

  // Environment: dc_rom with one-cycle registered read and clock enable
  logic [8:0]  ma_mem [1024];
  logic [15:0] mc_mem [1024];
  logic [9:0]  rom_addr_q;
  always @(posedge clk) if (rom_cen) rom_addr_q <= rom_a;
  assign rom_ma = ma_mem[rom_addr_q];
  assign rom_mc = mc_mem[rom_addr_q];

  typedef struct {
    logic [9:0]  a;
    logic        cen;
    logic        valid;
    logic [15:0] mc;
    logic [9:0]  cur;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  // Reference model state
  bit         m_run;
  logic [9:0] m_cur;
  logic       m_err;
  logic [9:0] m_romaddr;
  logic [8:0] m_stack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rom_a",    32'(rom_a),    32'(e.a));
        chk("rom_cen",  32'(rom_cen),  32'(e.cen));
        chk("mc_valid", 32'(mc_valid), 32'(e.valid));
        chk("cur_addr", 32'(cur_addr), 32'(e.cur));
        chk("stk_err",  32'(stk_err),  32'(e.err));
        if (e.valid) chk("mc_out", 32'(mc_out), 32'(e.mc));
      end
    end
  end

  initial begin : stim
    exp_t e;
    logic [8:0] ma_now;
    int ph, jp, rp, sp_pct;
    for (int i = 0; i < 1024; i++) begin
      ma_mem[i] = 9'($urandom);
      mc_mem[i] = 16'($urandom);
    end
    ma_mem[0] = 9'h011;
    rst = 1'b1; ax = 1'b0; stall = 1'b0; trap_req = 1'b0; jmp_req = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; jmp_addr = '0;
    repeat (3) @(posedge clk);
    m_run = 1'b0; m_cur = 10'h000; m_err = 1'b0; m_romaddr = 10'h000;
    m_stack.delete();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      ph = (cyc / 150) % 3;
      jp     = (ph == 0) ? 50 : (ph == 1) ? 10 : 25;
      rp     = (ph == 0) ? 10 : (ph == 1) ? 60 : 25;
      sp_pct = (ph == 2) ? 25 : 8;
      rst      = (cyc < 2) || ($urandom_range(0, 399) == 0);
      stall    = ($urandom_range(0, 99) < sp_pct);
      trap_req = ($urandom_range(0, 99) < 3);
      jmp_req  = ($urandom_range(0, 99) < jp);
      call_en  = ($urandom_range(0, 99) < 70);
      ret_en   = ($urandom_range(0, 99) < rp);
      jmp_addr = 9'($urandom);
      ax       = ($urandom_range(0, 7) == 0);

      ma_now  = ma_mem[m_romaddr];
      e.mc    = mc_mem[m_romaddr];
      e.cur   = m_cur;
      e.err   = m_err;
      e.cen   = 1'b1;
      e.valid = m_run;
      if (!m_run) begin
        e.a = {ax, 9'h000};
      end else if (stall) begin
        e.cen = 1'b0;
        e.a   = m_cur;
      end else if (trap_req) begin
        e.a = {ax, 9'h008};
        if (!rst) m_stack.delete();
      end else if (jmp_req) begin
        e.a = {ax, jmp_addr};
        if (call_en && !rst) begin
          if (m_stack.size() == DEPTH) m_err = 1'b1;
          else m_stack.push_back(ma_now);
        end
      end else if (ret_en) begin
        if (m_stack.size() == 0) begin
          e.a = {ax, ma_now};
          if (!rst) m_err = 1'b1;
        end else begin
          e.a = {ax, m_stack[m_stack.size()-1]};
          if (!rst) void'(m_stack.pop_back());
        end
      end else begin
        e.a = {ax, ma_now};
      end
      sbq.push_back(e);

      // Commit model state as of the coming edge
      if (e.cen) m_romaddr = e.a;
      if (rst) begin
        m_run = 1'b0; m_cur = 10'h000; m_err = 1'b0; m_stack.delete();
      end else begin
        m_run = 1'b1;
        if (e.cen) m_cur = e.a;
      end
    end

    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sbq.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
